// File: rtl/nibble_mem_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_mem_driver_if
//  Description : Command/response bundle between a host and nibble_mem_driver.
//  Revision    : 1.0 - initial release
// ============================================================================
interface nibble_mem_driver_if #(
    parameter int ADDR_W = 6
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [ADDR_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [3:0]        rsp_data;
    logic [ADDR_W-1:0] rsp_addr;
    logic              busy;

    modport master (
        output cmd_valid, cmd_op, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_addr, busy
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_addr, busy
    );
endinterface
`default_nettype wire

// File: rtl/nibble_mem_driver.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_mem_driver
//  Description : Turns valid/ready commands into timed store/next/prev presses
//                for the nibble memory, tracking a shadow address.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_mem_driver #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4,
    parameter int ADDR_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_mem_driver_if.slave   bus,
    output logic [3:0]           mem_din,
    output logic                 mem_store,
    output logic                 mem_next,
    output logic                 mem_prev,
    input  logic [3:0]           mem_dout
);

    localparam logic [2:0] c_st_idle    = 3'd0;
    localparam logic [2:0] c_st_decide  = 3'd1;
    localparam logic [2:0] c_st_press   = 3'd2;
    localparam logic [2:0] c_st_release = 3'd3;
    localparam logic [2:0] c_st_resp    = 3'd4;

    localparam logic [1:0] c_op_store = 2'b00;
    localparam logic [1:0] c_op_next  = 2'b01;
    localparam logic [1:0] c_op_prev  = 2'b10;
    localparam logic [1:0] c_op_seek  = 2'b11;

    localparam logic [3:0]        c_hold_last = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0]        c_gap_last  = 4'(GAP_CYCLES - 1);
    localparam logic [ADDR_W-1:0] c_half      = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] c_one       = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [2:0]        r_state;
    logic [3:0]        r_cnt;
    logic [ADDR_W-1:0] r_shadow;
    logic [ADDR_W-1:0] r_target;
    logic [1:0]        r_op;
    logic              r_dir_prev;
    logic              r_first;
    logic [3:0]        r_mem_din;
    logic              r_mem_store;
    logic              r_mem_next;
    logic              r_mem_prev;
    logic              r_cmd_ready;
    logic              r_busy;
    logic              r_rsp_valid;
    logic [3:0]        r_rsp_data;
    logic [ADDR_W-1:0] r_rsp_addr;

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_cnt_nxt;
    logic [ADDR_W-1:0] w_shadow_nxt;
    logic [ADDR_W-1:0] w_target_nxt;
    logic [1:0]        w_op_nxt;
    logic              w_dir_prev_nxt;
    logic              w_first_nxt;
    logic [3:0]        w_mem_din_nxt;
    logic              w_mem_store_nxt;
    logic              w_mem_next_nxt;
    logic              w_mem_prev_nxt;
    logic              w_cmd_ready_nxt;
    logic              w_busy_nxt;
    logic              w_rsp_valid_nxt;
    logic [3:0]        w_rsp_data_nxt;
    logic [ADDR_W-1:0] w_rsp_addr_nxt;

    logic              w_accept;
    logic [ADDR_W-1:0] w_diff;
    logic              w_sel_store;
    logic              w_sel_next;
    logic              w_sel_prev;
    logic              w_in_press;

    // cmd_ready is registered high exactly while the state is IDLE
    assign w_accept = bus.cmd_valid & r_cmd_ready;
    assign w_diff   = r_target - r_shadow;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_st_idle;
            r_cnt       <= 4'd0;
            r_shadow    <= '0;
            r_target    <= '0;
            r_op        <= c_op_store;
            r_dir_prev  <= 1'b0;
            r_first     <= 1'b0;
            r_mem_din   <= 4'd0;
            r_mem_store <= 1'b0;
            r_mem_next  <= 1'b0;
            r_mem_prev  <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= 4'd0;
            r_rsp_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_shadow    <= w_shadow_nxt;
            r_target    <= w_target_nxt;
            r_op        <= w_op_nxt;
            r_dir_prev  <= w_dir_prev_nxt;
            r_first     <= w_first_nxt;
            r_mem_din   <= w_mem_din_nxt;
            r_mem_store <= w_mem_store_nxt;
            r_mem_next  <= w_mem_next_nxt;
            r_mem_prev  <= w_mem_prev_nxt;
            r_cmd_ready <= w_cmd_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_data  <= w_rsp_data_nxt;
            r_rsp_addr  <= w_rsp_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_state_nxt = (bus.cmd_op == c_op_seek) ? c_st_decide : c_st_press;
                    w_cnt_nxt   = 4'd0;
                end
            end
            c_st_decide: begin
                w_state_nxt = (w_diff == '0) ? c_st_resp : c_st_press;
                w_cnt_nxt   = 4'd0;
            end
            c_st_press: begin
                if (r_cnt == c_hold_last) begin
                    w_state_nxt = c_st_release;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            c_st_release: begin
                if (r_cnt == c_gap_last) begin
                    w_state_nxt = (r_op == c_op_seek) ? c_st_decide : c_st_resp;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt   = r_cnt + 4'd1;
                end
            end
            c_st_resp: begin
                w_state_nxt = c_st_idle;
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_shadow_nxt   = r_shadow;
        w_target_nxt   = r_target;
        w_op_nxt       = r_op;
        w_dir_prev_nxt = r_dir_prev;
        w_first_nxt    = r_first;
        w_mem_din_nxt  = r_mem_din;
        w_rsp_data_nxt = r_rsp_data;

        case (r_state)
            c_st_idle: begin
                if (w_accept) begin
                    w_op_nxt     = bus.cmd_op;
                    w_target_nxt = bus.cmd_data;
                    w_first_nxt  = 1'b1;
                    if (bus.cmd_op == c_op_store) begin
                        w_mem_din_nxt = bus.cmd_data[3:0];
                    end
                end
            end
            c_st_decide: begin
                // Direction is latched on the first decision only, ties go forward
                if (r_first) begin
                    w_dir_prev_nxt = (w_diff > c_half);
                    w_first_nxt    = 1'b0;
                    if (w_diff == '0) begin
                        w_rsp_data_nxt = mem_dout;
                    end
                end
            end
            c_st_press: begin
                if (w_state_nxt == c_st_release) begin
                    w_shadow_nxt = r_mem_prev ? (r_shadow - c_one) : (r_shadow + c_one);
                end
            end
            c_st_release: begin
                if (r_cnt == c_gap_last) begin
                    w_rsp_data_nxt = mem_dout;
                end
            end
            default: begin
            end
        endcase

        w_sel_store = (w_op_nxt == c_op_store);
        w_sel_next  = (w_op_nxt == c_op_next) || ((w_op_nxt == c_op_seek) && !w_dir_prev_nxt);
        w_sel_prev  = (w_op_nxt == c_op_prev) || ((w_op_nxt == c_op_seek) && w_dir_prev_nxt);
        w_in_press  = (w_state_nxt == c_st_press);

        w_mem_store_nxt = w_in_press & w_sel_store;
        w_mem_next_nxt  = w_in_press & w_sel_next;
        w_mem_prev_nxt  = w_in_press & w_sel_prev;

        w_cmd_ready_nxt = (w_state_nxt == c_st_idle);
        w_busy_nxt      = (w_state_nxt != c_st_idle);
        w_rsp_valid_nxt = (w_state_nxt == c_st_resp);
        w_rsp_addr_nxt  = (w_state_nxt == c_st_resp) ? r_shadow : r_rsp_addr;
    end

    assign bus.cmd_ready = r_cmd_ready;
    assign bus.busy      = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_addr  = r_rsp_addr;
    assign mem_din       = r_mem_din;
    assign mem_store     = r_mem_store;
    assign mem_next      = r_mem_next;
    assign mem_prev      = r_mem_prev;

endmodule
`default_nettype wire

// File: tb/tb_nibble_mem_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_mem_driver
//  Description : Directed bench for nibble_mem_driver with a nibble memory model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_mem_driver;

    localparam logic [1:0] c_store = 2'b00;
    localparam logic [1:0] c_next  = 2'b01;
    localparam logic [1:0] c_prev  = 2'b10;
    localparam logic [1:0] c_seek  = 2'b11;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] mem_din;
    logic       mem_store;
    logic       mem_next;
    logic       mem_prev;
    logic [3:0] mem_dout;

    nibble_mem_driver_if #(.ADDR_W(6)) bus ();

    nibble_mem_driver #(
        .HOLD_CYCLES (4),
        .GAP_CYCLES  (4),
        .ADDR_W      (6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .mem_din   (mem_din),
        .mem_store (mem_store),
        .mem_next  (mem_next),
        .mem_prev  (mem_prev),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    // Nibble memory: 2-FF synchroniser plus rising-edge detect on each button
    logic [3:0] m_mem [64];
    logic [5:0] m_addr;
    logic [2:0] m_s1, m_s2, m_s3;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_addr <= 6'd0;
            m_s1   <= 3'd0;
            m_s2   <= 3'd0;
            m_s3   <= 3'd0;
            for (int i = 0; i < 64; i++) m_mem[i] <= 4'd0;
        end else begin
            m_s1 <= {mem_store, mem_next, mem_prev};
            m_s2 <= m_s1;
            m_s3 <= m_s2;
            if (m_s2[2] && !m_s3[2]) begin
                m_mem[m_addr] <= mem_din;
                m_addr        <= m_addr + 6'd1;
            end else if (m_s2[1] && !m_s3[1]) begin
                m_addr <= m_addr + 6'd1;
            end else if (m_s2[0] && !m_s3[0]) begin
                m_addr <= m_addr - 6'd1;
            end
        end
    end

    assign mem_dout = m_mem[m_addr];

    int         total = 0;
    int         bad   = 0;
    int         lat, n_st, n_nx, n_pv, first_hi, last_hi, multi;
    logic [5:0] got_addr;
    logic [3:0] got_data;
    logic [3:0] din_c1;
    int         rsp_cnt, ready_first, din_k2, no_rsp;
    logic [5:0] addr2;
    logic [2:0] lines, last_lines;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [5:0] data);
        bit done;
        done = 1'b0;
        n_st = 0; n_nx = 0; n_pv = 0; first_hi = 0; last_hi = 0; multi = 0; lat = 0;
        last_lines = 3'd0;
        @(negedge clk);
        check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = c_store;
        bus.cmd_data  = 6'h3F;
        din_c1        = mem_din;
        for (int k = 1; k <= 400 && !done; k++) begin
            if (k > 1) @(negedge clk);
            lines = {mem_store, mem_next, mem_prev};
            if (lines[2] && !last_lines[2]) n_st++;
            if (lines[1] && !last_lines[1]) n_nx++;
            if (lines[0] && !last_lines[0]) n_pv++;
            if (|lines) begin
                if (first_hi == 0) first_hi = k;
                last_hi = k;
            end
            if ($countones(lines) > 1) multi++;
            last_lines = lines;
            if (bus.rsp_valid) begin
                done     = 1'b1;
                lat      = k;
                got_addr = bus.rsp_addr;
                got_data = bus.rsp_data;
            end
        end
        check("rsp_timeout", 32'(done), 32'd1);
    endtask

    task automatic expect_rsp(input string tag, input int e_lat, input int e_addr, input int e_data,
                              input int e_st, input int e_nx, input int e_pv);
        check($sformatf("%s.latency", tag), lat, e_lat);
        check($sformatf("%s.rsp_addr", tag), 32'(got_addr), e_addr);
        check($sformatf("%s.rsp_data", tag), 32'(got_data), e_data);
        check($sformatf("%s.store_pulses", tag), n_st, e_st);
        check($sformatf("%s.next_pulses", tag), n_nx, e_nx);
        check($sformatf("%s.prev_pulses", tag), n_pv, e_pv);
        check($sformatf("%s.multi_line", tag), multi, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = c_store;
        bus.cmd_data  = 6'd0;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst.busy", 32'(bus.busy), 32'd0);
        check("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst.rsp_addr", 32'(bus.rsp_addr), 32'd0);
        check("rst.rsp_data", 32'(bus.rsp_data), 32'd0);
        check("rst.mem_din", 32'(mem_din), 32'd0);
        check("rst.lines", 32'({mem_store, mem_next, mem_prev}), 32'd0);
        rst_n = 1'b1;

        // STORE with upper cmd_data bits set: only the low nibble reaches mem_din
        run_cmd(c_store, 6'h3A);
        expect_rsp("store_a", 9, 1, 0, 1, 0, 0);
        check("store_a.first_hi", first_hi, 1);
        check("store_a.last_hi", last_hi, 4);
        check("store_a.din", 32'(din_c1), 32'hA);
        check("store_a.din_held", 32'(mem_din), 32'hA);

        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        run_cmd(c_prev, 6'd0);
        expect_rsp("prev_wrap", 9, 63, 0, 0, 0, 1);
        check("prev_wrap.hold", last_hi - first_hi + 1, 4);
        run_cmd(c_next, 6'd0);
        expect_rsp("next_wrap", 9, 0, 0, 0, 1, 0);

        run_cmd(c_store, 6'h05);
        expect_rsp("store_5", 9, 1, 0, 1, 0, 0);
        run_cmd(c_seek, 6'd0);
        expect_rsp("seek_0", 11, 0, 5, 0, 0, 1);
        run_cmd(c_seek, 6'd62);
        expect_rsp("seek_62", 20, 62, 0, 0, 0, 2);
        run_cmd(c_seek, 6'd0);
        expect_rsp("seek_back", 20, 0, 5, 0, 2, 0);
        run_cmd(c_seek, 6'd32);
        expect_rsp("seek_tie", 290, 32, 0, 0, 32, 0);
        run_cmd(c_store, 6'h07);
        expect_rsp("store_7", 9, 33, 0, 1, 0, 0);
        run_cmd(c_prev, 6'd0);
        expect_rsp("prev_32", 9, 32, 7, 0, 0, 1);
        run_cmd(c_seek, 6'd32);
        expect_rsp("seek_self", 2, 32, 7, 0, 0, 0);

        // cmd_valid held through a STORE: a second (NEXT) command follows exactly once
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_store;
        bus.cmd_data  = 6'h03;
        @(negedge clk);
        bus.cmd_op    = c_next;
        bus.cmd_data  = 6'h0C;
        rsp_cnt = 0; ready_first = 0; n_st = 0; n_nx = 0; din_k2 = 0; addr2 = 6'd0;
        last_lines = 3'd0;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            if (ready_first != 0 && k == ready_first + 1) begin
                check("hold.ready_after_accept", 32'(bus.cmd_ready), 32'd0);
                bus.cmd_valid = 1'b0;
            end
            if (bus.cmd_ready && ready_first == 0) ready_first = k;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                if (rsp_cnt == 2) addr2 = bus.rsp_addr;
            end
            lines = {mem_store, mem_next, mem_prev};
            if (lines[2] && !last_lines[2]) n_st++;
            if (lines[1] && !last_lines[1]) n_nx++;
            last_lines = lines;
            if (k == 2) din_k2 = int'(mem_din);
        end
        bus.cmd_valid = 1'b0;
        check("hold.ready_first", ready_first, 10);
        check("hold.rsp_count", rsp_cnt, 2);
        check("hold.store_pulses", n_st, 1);
        check("hold.next_pulses", n_nx, 1);
        check("hold.din_captured", din_k2, 3);
        check("hold.second_addr", 32'(addr2), 32'd34);
        check("hold.din_after_next", 32'(mem_din), 32'd3);

        // Reset during the second cycle of a press
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = c_store;
        bus.cmd_data  = 6'h09;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("midrst.store_high", 32'(mem_store), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst.lines", 32'({mem_store, mem_next, mem_prev}), 32'd0);
        check("midrst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("midrst.busy", 32'(bus.busy), 32'd0);
        check("midrst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("midrst.rsp_addr", 32'(bus.rsp_addr), 32'd0);
        rst_n = 1'b1;
        no_rsp = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid) no_rsp++;
        end
        check("midrst.no_rsp", no_rsp, 0);
        run_cmd(c_next, 6'd0);
        expect_rsp("midrst.next", 9, 1, 0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
